chord_song_reader: RTL and testbench

- Producer side of the chord-player note interface: fetches song entries from an external song ROM and drives note, duration, voice and the new_note strobe into the three-voice chord player.
- Groups consecutive entries into chords of up to three voices.
- Advances to the next chord only after player_ready shows the player has finished the current chord.
- Sits between the top-level song/play controls and the chord player.

---
 rtl/chord_pkg.sv | 24 ++
 rtl/chord_song_reader.sv | 150 +++++++++++++++
 tb/tb_chord_song_reader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chord_pkg.sv
// Shared types and ROM field layout for the chord song reader.
package chord_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StData,
        StIssue,
        StWaitBusy,
        StWaitReady,
        StDone
    } state_t;

    localparam int unsigned ROM_W     = 13;
    localparam int unsigned CHORD_BIT = 12;
    localparam int unsigned NOTE_MSB  = 11;
    localparam int unsigned NOTE_LSB  = 6;
    localparam int unsigned DUR_MSB   = 5;

    localparam logic [5:0] END_DURATION = 6'd0;

    localparam int unsigned MAX_VOICES = 3;

endpackage

// File: rtl/chord_song_reader.sv
// Fetches song entries from the song ROM and feeds chords of up to three voices to the player.
// Optional CHORD_SONG_LOOP_EN: restart the song at its end instead of stopping in StDone.
module chord_song_reader #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned SONG_W     = 2,
    parameter int unsigned MAX_VOICES = chord_pkg::MAX_VOICES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic [SONG_W-1:0]              song,
    input  logic                           player_ready,
    output logic [SONG_W+ADDR_W-1:0]       rom_addr,
    input  logic [chord_pkg::ROM_W-1:0]    rom_data,
    output logic [5:0]                     note,
    output logic [5:0]                     duration,
    output logic [1:0]                     voice,
    output logic                           new_note,
    output logic                           song_done
);
    import chord_pkg::*;

    localparam logic [1:0] LAST_VOICE = 2'(MAX_VOICES - 1);

    state_t              state_q;
    logic [SONG_W-1:0]   song_latched_q;
    logic [ADDR_W-1:0]   index_q;
    logic [1:0]          voice_cnt_q;
    logic                chord_q;
    logic                last_q;
    logic                song_changed;
    logic                at_end_marker;
    logic                index_max;

    assign rom_addr      = {song_latched_q, index_q};
    assign index_max     = &index_q;
    assign at_end_marker = (rom_data[DUR_MSB:0] == END_DURATION);

    // IDLE latches the new song itself and DONE has its own exit check.
    assign song_changed = (song != song_latched_q) && (state_q != StIdle) && (state_q != StDone);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            song_latched_q <= '0;
            index_q        <= '0;
            voice_cnt_q    <= '0;
            chord_q        <= 1'b0;
            last_q         <= 1'b0;
            note           <= '0;
            duration       <= '0;
            voice          <= '0;
            new_note       <= 1'b0;
            song_done      <= 1'b0;
        end else begin
            // Strobe is cleared even while paused so a pulse is never stretched.
            new_note <= 1'b0;
`ifdef CHORD_SONG_LOOP_EN
            song_done <= 1'b0;
`endif
            if (song_changed) begin
                state_q     <= StIdle;
                index_q     <= '0;
                voice_cnt_q <= '0;
                voice       <= '0;
                last_q      <= 1'b0;
            end else if (play) begin
                case (state_q)
                    StIdle: begin
                        song_latched_q <= song;
                        index_q        <= '0;
                        voice_cnt_q    <= '0;
                        last_q         <= 1'b0;
                        song_done      <= 1'b0;
                        state_q        <= StFetch;
                    end
                    StFetch: begin
                        state_q <= StData;
                    end
                    StData: begin
                        if (at_end_marker) begin
                            song_done <= 1'b1;
`ifdef CHORD_SONG_LOOP_EN
                            index_q     <= '0;
                            voice_cnt_q <= '0;
                            state_q     <= StFetch;
`else
                            state_q     <= StDone;
`endif
                        end else begin
                            note     <= rom_data[NOTE_MSB:NOTE_LSB];
                            duration <= rom_data[DUR_MSB:0];
                            voice    <= voice_cnt_q;
                            chord_q  <= rom_data[CHORD_BIT];
                            new_note <= 1'b1;
                            state_q  <= StIssue;
                        end
                    end
                    StIssue: begin
                        // The last entry slot ends the song; the index never wraps.
                        if (index_max) begin
                            last_q <= 1'b1;
                        end else begin
                            index_q <= index_q + ADDR_W'(1);
                        end
                        if (chord_q && (voice_cnt_q < LAST_VOICE) && !index_max) begin
                            voice_cnt_q <= voice_cnt_q + 2'd1;
                            state_q     <= StFetch;
                        end else begin
                            state_q <= StWaitBusy;
                        end
                    end
                    StWaitBusy: begin
                        // A ready level left over from the previous chord is ignored.
                        if (!player_ready) begin
                            state_q <= StWaitReady;
                        end
                    end
                    StWaitReady: begin
                        if (player_ready) begin
                            voice_cnt_q <= '0;
                            if (last_q) begin
                                song_done <= 1'b1;
`ifdef CHORD_SONG_LOOP_EN
                                index_q <= '0;
                                last_q  <= 1'b0;
                                state_q <= StFetch;
`else
                                state_q <= StDone;
`endif
                            end else begin
                                state_q <= StFetch;
                            end
                        end
                    end
                    StDone: begin
                        if (song != song_latched_q) begin
                            song_done <= 1'b0;
                            state_q   <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chord_song_reader.sv
// Directed bench for chord_song_reader with a behavioural song ROM (1-cycle read latency).
module tb_chord_song_reader;

    logic        clk;
    logic        reset;
    logic        play;
    logic [1:0]  song;
    logic        player_ready;
    logic [6:0]  rom_addr;
    logic [12:0] rom_data;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic [1:0]  voice;
    logic        new_note;
    logic        song_done;

    logic [12:0] mem [0:127];
    int checks;
    int errors;

    chord_song_reader #(
        .ADDR_W    (5),
        .SONG_W    (2),
        .MAX_VOICES(3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .play        (play),
        .song        (song),
        .player_ready(player_ready),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .note        (note),
        .duration    (duration),
        .voice       (voice),
        .new_note    (new_note),
        .song_done   (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    function automatic logic [12:0] ent(input logic cf, input int n, input int d);
        return {cf, 6'(n), 6'(d)};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Cycles until new_note is seen, bounded.
    task automatic wait_note(input int exp, input string tag);
        int n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!new_note && n < 20);
        check({tag, "_latency"}, 32'(n), 32'(exp));
    endtask

    task automatic quiet(input int n, input string tag);
        int cnt;
        cnt = 0;
        repeat (n) begin
            tick(1);
            if (new_note) cnt++;
        end
        check({tag, "_quiet"}, 32'(cnt), 0);
    endtask

    // Ready drops one cycle after the note and rises three cycles later.
    task automatic handshake(input string tag);
        tick(1);
        check({tag, "_pulse"}, 32'(new_note), 0);
        player_ready = 1'b0;
        quiet(3, tag);
        player_ready = 1'b1;
    endtask

    task automatic restart(input logic [1:0] s);
        reset        = 1'b1;
        play         = 1'b0;
        player_ready = 1'b1;
        tick(2);
        song  = s;
        reset = 1'b0;
        tick(1);
    endtask

    task automatic check_note(input string tag, input int n, input int d, input int v);
        check({tag, "_note"}, 32'(note), 32'(n));
        check({tag, "_dur"}, 32'(duration), 32'(d));
        check({tag, "_voice"}, 32'(voice), 32'(v));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        play         = 1'b0;
        song         = 2'd0;
        player_ready = 1'b1;
        for (int k = 0; k < 128; k++) mem[k] = 13'd0;
        mem[0]  = ent(0, 10, 4);
        mem[1]  = ent(0, 12, 2);
        mem[32] = ent(1, 20, 8);
        mem[33] = ent(1, 24, 8);
        mem[34] = ent(0, 27, 8);
        mem[64] = ent(1, 30, 1);
        mem[65] = ent(1, 31, 2);
        mem[66] = ent(1, 32, 3);
        mem[67] = ent(1, 33, 4);
        mem[68] = ent(0, 34, 5);
        for (int i = 0; i < 32; i++) mem[96 + i] = ent(0, i + 1, 1);

        // Reset state
        tick(2);
        check("rst_addr", 32'(rom_addr), 0);
        check_note("rst", 0, 0, 0);
        check("rst_new_note", 32'(new_note), 0);
        check("rst_done", 32'(song_done), 0);
        reset = 1'b0;
        tick(2);
        check("idle_new_note", 32'(new_note), 0);

        // Single notes, song 0
        play = 1'b1;
        wait_note(3, "s0_n0");
        check_note("s0_n0", 10, 4, 0);
        check("s0_n0_addr", 32'(rom_addr), 0);
        handshake("s0_n0");
        wait_note(3, "s0_n1");
        check_note("s0_n1", 12, 2, 0);
        check("s0_n1_addr", 32'(rom_addr), 1);
        handshake("s0_n1");
        tick(3);
        check("s0_end_done", 32'(song_done), 1);
        check("s0_end_new_note", 32'(new_note), 0);
`ifdef CHORD_SONG_LOOP_EN
        check("s0_loop_addr", 32'(rom_addr), 0);
        tick(1);
        check("s0_loop_pulse", 32'(song_done), 0);
`else
        check("s0_end_addr", 32'(rom_addr), 2);
        quiet(8, "s0_done");
        check("s0_done_hold", 32'(song_done), 1);
        song = 2'd1;
        tick(1);
        check("s0_done_exit", 32'(song_done), 0);
`endif

        // Three-voice chord, song 1
        restart(2'd1);
        play = 1'b1;
        wait_note(3, "s1_v0");
        check_note("s1_v0", 20, 8, 0);
        wait_note(3, "s1_v1");
        check_note("s1_v1", 24, 8, 1);
        wait_note(3, "s1_v2");
        check_note("s1_v2", 27, 8, 2);
        quiet(8, "s1_stale");
        check("s1_stale_addr", 32'(rom_addr), 35);
        player_ready = 1'b0;
        tick(1);
        player_ready = 1'b1;
        tick(3);
        check("s1_end_done", 32'(song_done), 1);
        check("s1_end_new_note", 32'(new_note), 0);

        // Chord truncation and pause, song 2
        restart(2'd2);
        play = 1'b1;
        wait_note(3, "s2_v0");
        check_note("s2_v0", 30, 1, 0);
        wait_note(3, "s2_v1");
        check_note("s2_v1", 31, 2, 1);
        wait_note(3, "s2_v2");
        check_note("s2_v2", 32, 3, 2);
        quiet(4, "s2_trunc");
        check("s2_trunc_addr", 32'(rom_addr), 67);
        player_ready = 1'b0;
        tick(1);
        play         = 1'b0;
        player_ready = 1'b1;
        quiet(10, "s2_pause");
        check("s2_pause_addr", 32'(rom_addr), 67);
        check("s2_pause_voice", 32'(voice), 2);
        play = 1'b1;
        wait_note(3, "s2_v0b");
        check_note("s2_v0b", 33, 4, 0);
        play = 1'b0;
        tick(1);
        check("s2_issue_pause_pulse", 32'(new_note), 0);
        quiet(4, "s2_issue_pause");
        check("s2_issue_pause_addr", 32'(rom_addr), 67);
        play = 1'b1;
        wait_note(3, "s2_v1b");
        check_note("s2_v1b", 34, 5, 1);

        // Song change during FETCH, then reset mid-chord
        restart(2'd0);
        play = 1'b1;
        tick(1);
        check("chg_fetch_addr", 32'(rom_addr), 0);
        song = 2'd1;
        tick(1);
        check("chg_idle_new_note", 32'(new_note), 0);
        tick(1);
        check("chg_restart_addr", 32'(rom_addr), 32);
        wait_note(2, "chg_v0");
        check_note("chg_v0", 20, 8, 0);
        wait_note(3, "chg_v1");
        check_note("chg_v1", 24, 8, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_new_note", 32'(new_note), 0);
        check("mid_rst_addr", 32'(rom_addr), 0);
        check("mid_rst_done", 32'(song_done), 0);
        check_note("mid_rst", 0, 0, 0);

        // Full 32-entry song: index reaches all ones without a wrap
        restart(2'd3);
        play = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wait_note(3, "wrap");
            check("wrap_note", 32'(note), 32'(i + 1));
            tick(1);
            player_ready = 1'b0;
            tick(1);
            player_ready = 1'b1;
        end
        tick(1);
        check("wrap_done", 32'(song_done), 1);
`ifdef CHORD_SONG_LOOP_EN
        check("wrap_loop_addr", 32'(rom_addr), 96);
        tick(1);
        check("wrap_loop_pulse", 32'(song_done), 0);
`else
        check("wrap_end_addr", 32'(rom_addr), 127);
        quiet(6, "wrap_done");
        check("wrap_done_hold", 32'(song_done), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
